// File: rtl/gpio_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_mmio
//  Description : Memory-mapped GPIO: direction, output latch, synchronised
//                (optionally debounced) inputs, edge capture with W1C status
//                and a level interrupt. Debounce enabled by GPIO_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_mmio #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [31:0]      Adr_in,
    input  logic             MemWrite_in,
    input  logic [31:0]      Data_in,
    output logic [31:0]      Data_out,
    input  logic [WIDTH-1:0] gpio_port_in,
    output logic [WIDTH-1:0] gpio_port_out,
    output logic [WIDTH-1:0] gpio_port_oe,
    output logic             irq
);

    localparam logic [2:0] c_OFS_OUT  = 3'd0;
    localparam logic [2:0] c_OFS_DIR  = 3'd1;
    localparam logic [2:0] c_OFS_IN   = 3'd2;
    localparam logic [2:0] c_OFS_IEN  = 3'd3;
    localparam logic [2:0] c_OFS_STAT = 3'd4;
    localparam logic [2:0] c_OFS_MODE = 3'd5;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] edge_stat_q;
    logic [WIDTH-1:0] edge_stat_d;
    logic [WIDTH-1:0] edge_mode_q;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] w_in_val;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_wdata;
    logic [2:0]       w_ofs;
    logic             w_wr;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_wr     = sel & MemWrite_in;
    assign w_ofs    = Adr_in[4:2];
    assign w_wdata  = Data_in[WIDTH-1:0];
    assign w_unused = ^{Adr_in[31:5], Adr_in[1:0], Data_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q       <= '0;
            dir_q       <= '0;
            irq_en_q    <= '0;
            edge_mode_q <= '0;
            edge_stat_q <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
        end else begin
            if (w_wr) begin
                case (w_ofs)
                    c_OFS_OUT:  out_q       <= w_wdata;
                    c_OFS_DIR:  dir_q       <= w_wdata;
                    c_OFS_IEN:  irq_en_q    <= w_wdata;
                    c_OFS_MODE: edge_mode_q <= w_wdata;
                    default:    ;
                endcase
            end
            edge_stat_q <= edge_stat_d;
            sync1_q     <= gpio_port_in;
            sync2_q     <= sync1_q;
            prev_q      <= w_in_val;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    // A pin's filtered value only follows sync2 after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic             val_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
                val_q <= 1'b0;
            end else if (sync2_q[i] == val_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                val_q <= sync2_q[i];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign w_in_val[i] = val_q;
    end : g_debounce
`else
    logic [CNT_W-1:0] w_unused_cnt;

    assign w_unused_cnt = CNT_W'(DEBOUNCE_CYCLES);
    assign w_in_val     = sync2_q;
`endif

    // Output pins never report edges, so a DIR or EDGE_MODE change alone is silent.
    assign w_event = ~dir_q & ((edge_mode_q & prev_q & ~w_in_val) |
                               (~edge_mode_q & ~prev_q & w_in_val));

    always_comb begin
        edge_stat_d = edge_stat_q;
        if (w_wr && (w_ofs == c_OFS_STAT)) begin
            edge_stat_d = edge_stat_d & ~w_wdata;
        end
        edge_stat_d = edge_stat_d | w_event;
    end

    always_comb begin
        w_rdata = '0;
        if (sel) begin
            case (w_ofs)
                c_OFS_OUT:  w_rdata[WIDTH-1:0] = out_q;
                c_OFS_DIR:  w_rdata[WIDTH-1:0] = dir_q;
                c_OFS_IN:   w_rdata[WIDTH-1:0] = w_in_val;
                c_OFS_IEN:  w_rdata[WIDTH-1:0] = irq_en_q;
                c_OFS_STAT: w_rdata[WIDTH-1:0] = edge_stat_q;
                c_OFS_MODE: w_rdata[WIDTH-1:0] = edge_mode_q;
                default:    ;
            endcase
        end
    end

    assign Data_out      = w_rdata;
    assign gpio_port_out = out_q;
    assign gpio_port_oe  = dir_q;
    assign irq           = |(edge_stat_q & irq_en_q);

endmodule : gpio_mmio
`default_nettype wire

// File: tb/tb_gpio_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_mmio
//  Description : Directed table-driven bench for gpio_mmio (WIDTH=8), plus
//                hand sequences for edge capture, W1C races and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_mmio;

    localparam int WIDTH = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    localparam logic [2:0] c_OUT  = 3'd0;
    localparam logic [2:0] c_DIR  = 3'd1;
    localparam logic [2:0] c_IN   = 3'd2;
    localparam logic [2:0] c_IEN  = 3'd3;
    localparam logic [2:0] c_STAT = 3'd4;
    localparam logic [2:0] c_MODE = 3'd5;

    logic             clk;
    logic             rst;
    logic             sel;
    logic [31:0]      Adr_in;
    logic             MemWrite_in;
    logic [31:0]      Data_in;
    logic [31:0]      Data_out;
    logic [WIDTH-1:0] gpio_port_in;
    logic [WIDTH-1:0] gpio_port_out;
    logic [WIDTH-1:0] gpio_port_oe;
    logic             irq;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_mmio #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sel           (sel),
        .Adr_in        (Adr_in),
        .MemWrite_in   (MemWrite_in),
        .Data_in       (Data_in),
        .Data_out      (Data_out),
        .gpio_port_in  (gpio_port_in),
        .gpio_port_out (gpio_port_out),
        .gpio_port_oe  (gpio_port_oe),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  ofs;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] ofs, input logic [31:0] data);
        @(negedge clk);
        sel         = 1'b1;
        MemWrite_in = 1'b1;
        Adr_in      = {27'd0, ofs, 2'b00};
        Data_in     = data;
        @(negedge clk);
        sel         = 1'b0;
        MemWrite_in = 1'b0;
        Data_in     = '0;
    endtask

    task automatic bus_read(input logic [2:0] ofs, output logic [31:0] data);
        sel         = 1'b1;
        MemWrite_in = 1'b0;
        Adr_in      = {27'd0, ofs, 2'b00};
        #1;
        data        = Data_out;
        sel         = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [2:0] ofs, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(ofs, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [31:0] d;

        rst          = 1'b0;
        sel          = 1'b0;
        Adr_in       = '0;
        MemWrite_in  = 1'b0;
        Data_in      = '0;
        gpio_port_in = '0;

        //            wr    ofs     wdata          exp_rd         out    oe     irq
        vecs[0]  = '{1'b0, c_OUT,  32'h0,         32'h0,         8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, c_DIR,  32'h0,         32'h0,         8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, c_IN,   32'h0,         32'h0,         8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, c_IEN,  32'h0,         32'h0,         8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, c_STAT, 32'h0,         32'h0,         8'h00, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, c_MODE, 32'h0,         32'h0,         8'h00, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 3'd6,   32'h0,         32'h0,         8'h00, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 3'd7,   32'h0,         32'h0,         8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, c_DIR,  32'h0000_00FF, 32'h0000_00FF, 8'h00, 8'hFF, 1'b0};
        vecs[9]  = '{1'b1, c_OUT,  32'h0000_00A5, 32'h0000_00A5, 8'hA5, 8'hFF, 1'b0};
        vecs[10] = '{1'b1, c_OUT,  32'hFFFF_FF3C, 32'h0000_003C, 8'h3C, 8'hFF, 1'b0};
        vecs[11] = '{1'b1, c_IN,   32'h0000_00FF, 32'h0000_0000, 8'h3C, 8'hFF, 1'b0};
        vecs[12] = '{1'b1, 3'd6,   32'hFFFF_FFFF, 32'h0000_0000, 8'h3C, 8'hFF, 1'b0};
        vecs[13] = '{1'b1, c_IEN,  32'hFFFF_FF08, 32'h0000_0008, 8'h3C, 8'hFF, 1'b0};
        vecs[14] = '{1'b1, c_MODE, 32'h0000_000F, 32'h0000_000F, 8'h3C, 8'hFF, 1'b0};
        vecs[15] = '{1'b1, c_STAT, 32'h0000_00FF, 32'h0000_0000, 8'h3C, 8'hFF, 1'b0};
        vecs[16] = '{1'b1, c_DIR,  32'h0000_0000, 32'h0000_0000, 8'h3C, 8'h00, 1'b0};
        vecs[17] = '{1'b1, c_MODE, 32'h0000_0000, 32'h0000_0000, 8'h3C, 8'h00, 1'b0};
        vecs[18] = '{1'b0, c_STAT, 32'h0,         32'h0,         8'h3C, 8'h00, 1'b0};

        wait_edges(2);
        check("reset_data_out_unselected", Data_out, 32'h0);
        rst = 1'b1;
        wait_edges(1);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].ofs, vecs[i].wdata);
            bus_read(vecs[i].ofs, d);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
            check($sformatf("vec%0d_out", i), {24'd0, gpio_port_out}, {24'd0, vecs[i].exp_out});
            check($sformatf("vec%0d_oe", i), {24'd0, gpio_port_oe}, {24'd0, vecs[i].exp_oe});
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end
        check("unselected_read_zero", Data_out, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // Debounce: short glitch filtered, held level accepted after 4 cycles.
        gpio_port_in[0] = 1'b1;
        wait_edges(3);
        gpio_port_in[0] = 1'b0;
        wait_edges(10);
        check_reg("db_glitch_in", c_IN, 32'h0);
        check_reg("db_glitch_stat", c_STAT, 32'h0);
        gpio_port_in[0] = 1'b1;
        wait_edges(5);
        check_reg("db_hold_in_n4", c_IN, 32'h0);
        wait_edges(1);
        check_reg("db_hold_in_n5", c_IN, 32'h1);
        check_reg("db_hold_stat_n5", c_STAT, 32'h0);
        wait_edges(1);
        check_reg("db_hold_stat_n6", c_STAT, 32'h1);
        gpio_port_in[0] = 1'b0;
        wait_edges(3 + DB);
        bus_write(c_STAT, 32'h1);
        check_reg("db_cleared", c_STAT, 32'h0);
`endif

        // Rising edge on pin 3 with IRQ_EN=0x08.
        gpio_port_in[3] = 1'b1;
        wait_edges(1 + DB);
        check_reg("rise_in_n", c_IN, 32'h0);
        wait_edges(1);
        check_reg("rise_in_n1", c_IN, 32'h08);
        check_reg("rise_stat_n1", c_STAT, 32'h0);
        check("rise_irq_n1", {31'd0, irq}, 32'h0);
        wait_edges(1);
        check_reg("rise_stat_n2", c_STAT, 32'h08);
        check("rise_irq_n2", {31'd0, irq}, 32'h1);
        bus_write(c_STAT, 32'h08);
        check_reg("w1c_stat", c_STAT, 32'h0);
        check("w1c_irq", {31'd0, irq}, 32'h0);

        // Falling mode on pin 3; then DIR=1 suppresses both directions.
        bus_write(c_MODE, 32'h08);
        check_reg("mode_change_silent", c_STAT, 32'h0);
        gpio_port_in[3] = 1'b0;
        wait_edges(3 + DB);
        check_reg("fall_sets", c_STAT, 32'h08);
        bus_write(c_STAT, 32'h08);
        gpio_port_in[3] = 1'b1;
        wait_edges(3 + DB);
        check_reg("rise_ignored_in_fall_mode", c_STAT, 32'h0);
        bus_write(c_DIR, 32'h08);
        gpio_port_in[3] = 1'b0;
        wait_edges(3 + DB);
        check_reg("dir_out_no_fall", c_STAT, 32'h0);
        gpio_port_in[3] = 1'b1;
        wait_edges(3 + DB);
        check_reg("dir_out_no_rise", c_STAT, 32'h0);
        bus_write(c_DIR, 32'h00);
        check_reg("dir_change_silent", c_STAT, 32'h0);

        // W1C landing on the same edge as a new falling event: set wins.
        gpio_port_in[3] = 1'b0;
        wait_edges(2 + DB);
        check_reg("race_pre_stat", c_STAT, 32'h0);
        sel         = 1'b1;
        MemWrite_in = 1'b1;
        Adr_in      = {27'd0, c_STAT, 2'b00};
        Data_in     = 32'h08;
        wait_edges(1);
        sel         = 1'b0;
        MemWrite_in = 1'b0;
        Data_in     = '0;
        check_reg("race_set_wins", c_STAT, 32'h08);
        bus_write(c_STAT, 32'h08);
        check_reg("race_cleared", c_STAT, 32'h0);

        // Build up state, then reset asynchronously mid-operation.
        bus_write(c_MODE, 32'h00);
        bus_write(c_IEN, 32'h0F);
        bus_write(c_DIR, 32'hF0);
        bus_write(c_OUT, 32'hFF);
        gpio_port_in = 8'h0F;
        wait_edges(3 + DB);
        check_reg("pre_rst_stat", c_STAT, 32'h0F);
        check("pre_rst_irq", {31'd0, irq}, 32'h1);
        check("pre_rst_oe", {24'd0, gpio_port_oe}, 32'hF0);
        gpio_port_in = 8'h00;
        wait_edges(2);
        #2;
        rst = 1'b0;
        #1;
        check("rst_out", {24'd0, gpio_port_out}, 32'h0);
        check("rst_oe", {24'd0, gpio_port_oe}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check_reg("rst_stat", c_STAT, 32'h0);
        check_reg("rst_ien", c_IEN, 32'h0);

        // Pads high at reset release yield a rising event.
        gpio_port_in = 8'h0F;
        wait_edges(1);
        rst = 1'b1;
        wait_edges(1);
        check_reg("post_rst_stat_e1", c_STAT, 32'h0);
        wait_edges(2 + DB);
        check_reg("post_rst_stat", c_STAT, 32'h0F);
        check("post_rst_irq_masked", {31'd0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gpio_mmio
`default_nettype wire
